ni_param_gen2: RTL and testbench

//  Second-generation GPU<->router network interface for the AI-Grid NoC leaf.

---
 rtl/ni_param_gen2.sv | 165 ++++++++++++++++
 tb/tb_ni_param_gen2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_param_gen2.sv
// GPU<->router network interface: egress dest-ID to routing-header mapping, ingress own-address filter.
// Each direction has a FIFO feeding a registered output stage; flits that are dropped are counted in saturating counters.

module ni_param_gen2_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_dat,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic [DATA_W-1:0]         out_dat,
  output logic                      out_vld,
  input  logic                      out_rdy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              out_vld_q, out_vld_d;
  logic              empty, push_en, pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign level   = level_q;
  assign out_dat = out_dat_q;
  assign out_vld = out_vld_q;

  // The output register refills whenever it is empty or being taken this cycle.
  always_comb begin
    empty     = (level_q == '0);
    push_en   = push & ~full;
    pop       = (~out_vld_q | out_rdy) & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      out_dat_d = mem_q[rd_ptr_q];
      out_vld_d = 1'b1;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
    level_d = level_q + LVL_W'(push_en) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
    end
  end
endmodule

module ni_param_gen2 #(
  parameter int GPU_ID     = 4,
  parameter int NUM_GPUS   = 32,
  parameter int DATA_W     = 16,
  parameter int HDR_W      = 6,
  parameter int ADDR_OFS   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             gpu_data_in,
  input  logic                          gpu_valid_in,
  output logic                          gpu_ready_out,
  output logic [DATA_W-1:0]             gpu_data_out,
  output logic                          gpu_valid_out,
  input  logic                          gpu_ready_in,
  output logic [DATA_W-1:0]             router_data_out,
  output logic                          router_valid_out,
  input  logic                          router_ready_in,
  input  logic [DATA_W-1:0]             router_data_in,
  input  logic                          router_valid_in,
  output logic                          router_ready_out,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [CNT_W-1:0]              bad_dest_cnt,
  output logic [CNT_W-1:0]              misroute_cnt,
  input  logic                          cnt_clr
);
  localparam int PAY_W = DATA_W - HDR_W;
  localparam logic [HDR_W-1:0] OFS      = HDR_W'(ADDR_OFS);
  localparam logic [HDR_W-1:0] OWN_ADDR = HDR_W'(GPU_ID + ADDR_OFS);

  logic              run_q;
  logic              tx_full, rx_full;
  logic              tx_push, rx_push, bad_inc, mis_inc;
  logic [DATA_W-1:0] tx_dat, rx_dat;
  logic [HDR_W-1:0]  gpu_dest, rtr_hdr;
  logic              dest_ok;
  logic [CNT_W-1:0]  bad_cnt_q, bad_cnt_d, mis_cnt_q, mis_cnt_d;

  // run_q keeps both ready pins low while reset is asserted.
  assign gpu_ready_out    = run_q & ~tx_full;
  assign router_ready_out = run_q & ~rx_full;
  assign bad_dest_cnt     = bad_cnt_q;
  assign misroute_cnt     = mis_cnt_q;

  always_comb begin
    gpu_dest  = gpu_data_in[DATA_W-1 -: HDR_W];
    rtr_hdr   = router_data_in[DATA_W-1 -: HDR_W];
    dest_ok   = (gpu_dest != '0) && (gpu_dest <= HDR_W'(NUM_GPUS));
    tx_push   = gpu_valid_in & gpu_ready_out & dest_ok;
    bad_inc   = gpu_valid_in & gpu_ready_out & ~dest_ok;
    rx_push   = router_valid_in & router_ready_out & (rtr_hdr == OWN_ADDR);
    mis_inc   = router_valid_in & router_ready_out & (rtr_hdr != OWN_ADDR);
    tx_dat    = {gpu_dest + OFS, gpu_data_in[PAY_W-1:0]};
    rx_dat    = {rtr_hdr - OFS, router_data_in[PAY_W-1:0]};
    bad_cnt_d = bad_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (cnt_clr) begin
      bad_cnt_d = '0;
      mis_cnt_d = '0;
    end else begin
      if (bad_inc && (bad_cnt_q != '1)) bad_cnt_d = bad_cnt_q + CNT_W'(1);
      if (mis_inc && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      bad_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      run_q     <= 1'b1;
      bad_cnt_q <= bad_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  ni_param_gen2_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_dat(tx_dat),
    .full(tx_full), .level(tx_level),
    .out_dat(router_data_out), .out_vld(router_valid_out), .out_rdy(router_ready_in)
  );

  ni_param_gen2_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_dat(rx_dat),
    .full(rx_full), .level(rx_level),
    .out_dat(gpu_data_out), .out_vld(gpu_valid_out), .out_rdy(gpu_ready_in)
  );
endmodule

// File: tb/tb_ni_param_gen2.sv
// Directed bench for ni_param_gen2 at default parameters (own addr 7, ADDR_OFS 3, 8-deep FIFOs).
module tb_ni_param_gen2;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpu_data_in, gpu_data_out, router_data_out, router_data_in;
  logic        gpu_valid_in, gpu_ready_out, gpu_valid_out, gpu_ready_in;
  logic        router_valid_out, router_ready_in, router_valid_in, router_ready_out;
  logic [3:0]  tx_level, rx_level;
  logic [7:0]  bad_dest_cnt, misroute_cnt;
  logic        cnt_clr;

  int n_cmp = 0;
  int n_err = 0;

  ni_param_gen2 dut (
    .clk(clk), .reset(reset),
    .gpu_data_in(gpu_data_in), .gpu_valid_in(gpu_valid_in), .gpu_ready_out(gpu_ready_out),
    .gpu_data_out(gpu_data_out), .gpu_valid_out(gpu_valid_out), .gpu_ready_in(gpu_ready_in),
    .router_data_out(router_data_out), .router_valid_out(router_valid_out),
    .router_ready_in(router_ready_in), .router_data_in(router_data_in),
    .router_valid_in(router_valid_in), .router_ready_out(router_ready_out),
    .tx_level(tx_level), .rx_level(rx_level),
    .bad_dest_cnt(bad_dest_cnt), .misroute_cnt(misroute_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    gpu_data_in = '0; gpu_valid_in = 1'b0; gpu_ready_in = 1'b0;
    router_data_in = '0; router_valid_in = 1'b0; router_ready_in = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset;
    gpu_data_in = 'x; gpu_valid_in = 1'bx; gpu_ready_in = 1'bx;
    router_data_in = 'x; router_valid_in = 1'bx; router_ready_in = 1'bx; cnt_clr = 1'bx;
    reset = 1'b1;
    repeat (3) tick;
    n_cmp++; if ({router_data_out, gpu_data_out} !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h want 0000/0000", router_data_out, gpu_data_out); end
    n_cmp++; if ({router_valid_out, gpu_valid_out, gpu_ready_out, router_ready_out} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000",
        {router_valid_out, gpu_valid_out, gpu_ready_out, router_ready_out}); end
    n_cmp++; if ({tx_level, rx_level, bad_dest_cnt, misroute_cnt} !== 24'h0) begin
      n_err++; $display("FAIL reset_lvl_cnt: got %h want 000000", {tx_level, rx_level, bad_dest_cnt, misroute_cnt}); end
    idle_inputs();
    reset = 1'b0;
    tick;
    n_cmp++; if ({gpu_ready_out, router_ready_out} !== 2'b11) begin
      n_err++; $display("FAIL reset_ready_after: got %b want 11", {gpu_ready_out, router_ready_out}); end
  endtask

  task automatic test_egress_map;
    router_ready_in = 1'b1;
    gpu_data_in = 16'h4005; gpu_valid_in = 1'b1;
    tick;
    gpu_valid_in = 1'b0;
    n_cmp++; if (router_valid_out !== 1'b0) begin
      n_err++; $display("FAIL egress_early: valid got %b want 0", router_valid_out); end
    tick;
    n_cmp++; if ({router_valid_out, router_data_out} !== {1'b1, 16'h4C05}) begin
      n_err++; $display("FAIL egress_map: got v=%b d=%h want v=1 d=4c05", router_valid_out, router_data_out); end
    tick;
    n_cmp++; if (router_valid_out !== 1'b0) begin
      n_err++; $display("FAIL egress_drain: valid got %b want 0", router_valid_out); end
    gpu_valid_in = 1'b1; gpu_data_in = 16'h0005;
    tick;
    gpu_data_in = 16'h8405;
    tick;
    gpu_valid_in = 1'b0;
    repeat (3) tick;
    n_cmp++; if ({router_valid_out, tx_level, bad_dest_cnt} !== {1'b0, 4'd0, 8'd2}) begin
      n_err++; $display("FAIL egress_bad_dest: got v=%b lvl=%0d cnt=%0d want v=0 lvl=0 cnt=2",
        router_valid_out, tx_level, bad_dest_cnt); end
  endtask

  task automatic test_ingress_filter;
    gpu_ready_in = 1'b1;
    router_valid_in = 1'b1; router_data_in = 16'h1C2A;
    tick;
    router_data_in = 16'h202A;
    n_cmp++; if (gpu_valid_out !== 1'b0) begin
      n_err++; $display("FAIL ingress_early: valid got %b want 0", gpu_valid_out); end
    tick;
    router_valid_in = 1'b0;
    n_cmp++; if ({gpu_valid_out, gpu_data_out} !== {1'b1, 16'h102A}) begin
      n_err++; $display("FAIL ingress_map: got v=%b d=%h want v=1 d=102a", gpu_valid_out, gpu_data_out); end
    tick;
    n_cmp++; if ({gpu_valid_out, misroute_cnt, rx_level} !== {1'b0, 8'd1, 4'd0}) begin
      n_err++; $display("FAIL ingress_filter: got v=%b cnt=%0d lvl=%0d want v=0 cnt=1 lvl=0",
        gpu_valid_out, misroute_cnt, rx_level); end
  endtask

  // The output register holds one flit beyond the 8 FIFO entries, so 9 are accepted.
  task automatic test_backpressure;
    logic [15:0] exp_q[$];
    logic [15:0] e;
    router_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (gpu_ready_out !== 1'b1) begin
        n_err++; $display("FAIL bp_ready_%0d: got %b want 1", i, gpu_ready_out); end
      gpu_valid_in = 1'b1;
      gpu_data_in = {6'(i + 1), 10'(i * 3 + 1)};
      exp_q.push_back({6'(i + 4), 10'(i * 3 + 1)});
      tick;
    end
    gpu_data_in = 16'h2BBB;
    n_cmp++; if ({tx_level, gpu_ready_out} !== {4'd8, 1'b0}) begin
      n_err++; $display("FAIL bp_full: got lvl=%0d rdy=%b want lvl=8 rdy=0", tx_level, gpu_ready_out); end
    tick;
    gpu_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({router_valid_out, router_data_out, tx_level} !== {1'b1, 16'h1001, 4'd8}) begin
        n_err++; $display("FAIL bp_stall_%0d: got v=%b d=%h lvl=%0d want v=1 d=1001 lvl=8",
          i, router_valid_out, router_data_out, tx_level); end
      tick;
    end
    router_ready_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if ({router_valid_out, router_data_out} !== {1'b1, e}) begin
        n_err++; $display("FAIL bp_drain_%0d: got v=%b d=%h want v=1 d=%h", i, router_valid_out, router_data_out, e); end
      tick;
    end
    n_cmp++; if ({router_valid_out, tx_level} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL bp_empty: got v=%b lvl=%0d want v=0 lvl=0", router_valid_out, tx_level); end
  endtask

  task automatic test_reset_mid;
    router_ready_in = 1'b0;
    gpu_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gpu_data_in = {6'(i + 10), 10'(i)};
      tick;
    end
    gpu_valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({router_valid_out, tx_level, gpu_ready_out} !== {1'b0, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL reset_async: got v=%b lvl=%0d rdy=%b want 0 0 0", router_valid_out, tx_level, gpu_ready_out); end
    tick;
    reset = 1'b0;
    router_ready_in = 1'b1;
    repeat (3) tick;
    n_cmp++; if ({router_valid_out, tx_level, gpu_ready_out} !== {1'b0, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL reset_discard: got v=%b lvl=%0d rdy=%b want 0 0 1", router_valid_out, tx_level, gpu_ready_out); end
  endtask

  task automatic test_stream;
    logic [15:0] tx_exp[$], rx_exp[$];
    logic [15:0] e;
    logic [5:0]  th;
    logic [9:0]  tp, rp;
    int tx_sent = 0, rx_sent = 0, tx_got = 0, rx_got = 0;
    for (int cyc = 0; cyc < 400 && (tx_got < 20 || rx_got < 20); cyc++) begin
      router_ready_in = cyc[0];
      gpu_ready_in = ~cyc[0];
      th = 6'(tx_sent % 32 + 1);
      tp = 10'(tx_sent * 37);
      rp = 10'(rx_sent + 100);
      gpu_valid_in = (tx_sent < 20);
      gpu_data_in = {th, tp};
      router_valid_in = (rx_sent < 20);
      router_data_in = {6'd7, rp};
      if (router_valid_out && router_ready_in) begin
        e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 16'hxxxx;
        n_cmp++; if (router_data_out !== e) begin
          n_err++; $display("FAIL stream_tx_%0d: got %h want %h", tx_got, router_data_out, e); end
        tx_got++;
      end
      if (gpu_valid_out && gpu_ready_in) begin
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 16'hxxxx;
        n_cmp++; if (gpu_data_out !== e) begin
          n_err++; $display("FAIL stream_rx_%0d: got %h want %h", rx_got, gpu_data_out, e); end
        rx_got++;
      end
      if (gpu_valid_in && gpu_ready_out) begin
        tx_exp.push_back({th + 6'd3, tp});
        tx_sent++;
      end
      if (router_valid_in && router_ready_out) begin
        rx_exp.push_back({6'd4, rp});
        rx_sent++;
      end
      tick;
    end
    idle_inputs();
    n_cmp++; if (tx_got != 20 || rx_got != 20) begin
      n_err++; $display("FAIL stream_count: got tx=%0d rx=%0d want 20/20", tx_got, rx_got); end
    n_cmp++; if ({tx_level, rx_level, bad_dest_cnt, misroute_cnt} !== 24'h0) begin
      n_err++; $display("FAIL stream_final: got %h want 000000", {tx_level, rx_level, bad_dest_cnt, misroute_cnt}); end
  endtask

  task automatic test_counters;
    gpu_ready_in = 1'b1;
    router_ready_in = 1'b1;
    router_valid_in = 1'b1; router_data_in = 16'h2000;
    gpu_valid_in = 1'b1; gpu_data_in = 16'h0005;
    repeat (100) tick;
    n_cmp++; if ({misroute_cnt, bad_dest_cnt} !== {8'd100, 8'd100}) begin
      n_err++; $display("FAIL cnt_100: got %0d/%0d want 100/100", misroute_cnt, bad_dest_cnt); end
    repeat (155) tick;
    n_cmp++; if ({misroute_cnt, bad_dest_cnt} !== {8'd255, 8'd255}) begin
      n_err++; $display("FAIL cnt_255: got %0d/%0d want 255/255", misroute_cnt, bad_dest_cnt); end
    repeat (45) tick;
    n_cmp++; if ({misroute_cnt, bad_dest_cnt, gpu_valid_out, router_valid_out} !== {8'd255, 8'd255, 2'b00}) begin
      n_err++; $display("FAIL cnt_sat: got %0d/%0d v=%b%b want 255/255 v=00",
        misroute_cnt, bad_dest_cnt, gpu_valid_out, router_valid_out); end
    cnt_clr = 1'b1;
    tick;
    n_cmp++; if ({misroute_cnt, bad_dest_cnt} !== 16'h0) begin
      n_err++; $display("FAIL cnt_clr_prio: got %0d/%0d want 0/0", misroute_cnt, bad_dest_cnt); end
    cnt_clr = 1'b0;
    tick;
    n_cmp++; if ({misroute_cnt, bad_dest_cnt} !== {8'd1, 8'd1}) begin
      n_err++; $display("FAIL cnt_resume: got %0d/%0d want 1/1", misroute_cnt, bad_dest_cnt); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_egress_map();
    test_ingress_filter();
    test_backpressure();
    test_reset_mid();
    test_stream();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
